// File: rtl/sd_cmd_engine_if.sv
// Register-side bus of the SD command engine: request fields in, status and response out.
// Response width follows SD_CMD_LONG_RESP_EN (128 bits with R2 support, 32 bits without).
interface sd_cmd_engine_if;
`ifdef SD_CMD_LONG_RESP_EN
  localparam int unsigned RESP_W = 128;
`else
  localparam int unsigned RESP_W = 32;
`endif

  logic              start;
  logic [5:0]        cmd_index;
  logic [31:0]       cmd_arg;
  logic [1:0]        resp_type;
  logic              busy;
  logic              done;
  logic              resp_timeout;
  logic              resp_crc_err;
  logic [RESP_W-1:0] resp;

  modport master (
    output start, cmd_index, cmd_arg, resp_type,
    input  busy, done, resp_timeout, resp_crc_err, resp
  );

  modport slave (
    input  start, cmd_index, cmd_arg, resp_type,
    output busy, done, resp_timeout, resp_crc_err, resp
  );
endinterface

// File: rtl/sd_cmd_engine.sv
// SD host CMD-line sequencer: serialises a 48-bit command with CRC7, then receives/checks the response.
// Define SD_CMD_LONG_RESP_EN for 136-bit (R2) responses; otherwise type 3 is handled as a 48-bit read.
module sd_crc7 (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clear,
  input  logic       enable,
  input  logic       in_bit,
  output logic [6:0] crc
);
  logic [6:0] crc_q, crc_d;
  logic       fb;

  // Serial CRC7, polynomial x^7 + x^3 + 1, MSB-first data
  always_comb begin
    fb    = in_bit ^ crc_q[6];
    crc_d = crc_q;
    if (clear) begin
      crc_d = '0;
    end else if (enable) begin
      crc_d = {crc_q[5:3], crc_q[2] ^ fb, crc_q[1:0], fb};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) crc_q <= '0;
    else          crc_q <= crc_d;
  end

  assign crc = crc_q;
endmodule

module sd_cmd_engine #(
  parameter int unsigned TIMEOUT_TICKS = 64
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           sd_tick,
  sd_cmd_engine_if.slave bus,
  output logic           cmd_out,
  output logic           cmd_oe,
  input  logic           cmd_in
);
`ifdef SD_CMD_LONG_RESP_EN
  localparam int unsigned RESP_W = 128;
  localparam int unsigned RX_W   = 136;
`else
  localparam int unsigned RESP_W = 32;
  localparam int unsigned RX_W   = 48;
`endif
  localparam int unsigned CNT_W  = $clog2(RX_W);
  localparam int unsigned WAIT_W = $clog2(TIMEOUT_TICKS + 1);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_TX_BODY   = 3'd1;
  localparam logic [2:0] ST_TX_CRC    = 3'd2;
  localparam logic [2:0] ST_TX_END    = 3'd3;
  localparam logic [2:0] ST_RESP_WAIT = 3'd4;
  localparam logic [2:0] ST_RESP_RX   = 3'd5;
  localparam logic [2:0] ST_DONE      = 3'd6;

  logic [2:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [39:0]       tx_sr_q, tx_sr_d;
  logic [RX_W-1:0]   rx_sr_q, rx_sr_d;
  logic [1:0]        rtype_q, rtype_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              tout_q, tout_d;
  logic              crcerr_q, crcerr_d;
  logic [RESP_W-1:0] resp_q, resp_d;
  logic              cmd_out_q, cmd_out_d;
  logic              cmd_oe_q, cmd_oe_d;

  logic              crc_clear_c, crc_en_c, crc_in_c;
  logic [6:0]        crc_w;
  logic              is_long_c;
  logic              crc_win_c;
  logic [CNT_W-1:0]  rx_last_c;

  sd_crc7 u_crc7 (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (crc_clear_c),
    .enable  (crc_en_c),
    .in_bit  (crc_in_c),
    .crc     (crc_w)
  );

  // Response geometry; cnt_q counts received bits with the start bit as 0
`ifdef SD_CMD_LONG_RESP_EN
  assign is_long_c = (rtype_q == 2'd3);
  assign rx_last_c = is_long_c ? CNT_W'(135) : CNT_W'(47);
  assign crc_win_c = is_long_c ? (cnt_q >= CNT_W'(8) && cnt_q <= CNT_W'(127))
                               : (cnt_q <= CNT_W'(39));
`else
  assign is_long_c = 1'b0;
  assign rx_last_c = CNT_W'(47);
  assign crc_win_c = (cnt_q <= CNT_W'(39));
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wait_d      = wait_q;
    tx_sr_d     = tx_sr_q;
    rx_sr_d     = rx_sr_q;
    rtype_d     = rtype_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    tout_d      = tout_q;
    crcerr_d    = crcerr_q;
    resp_d      = resp_q;
    cmd_out_d   = cmd_out_q;
    cmd_oe_d    = cmd_oe_q;
    crc_clear_c = 1'b0;
    crc_en_c    = 1'b0;
    crc_in_c    = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (bus.start) begin
          rtype_d     = bus.resp_type;
          tx_sr_d     = {2'b01, bus.cmd_index, bus.cmd_arg};
          tout_d      = 1'b0;
          crcerr_d    = 1'b0;
          crc_clear_c = 1'b1;
          busy_d      = 1'b1;
          cnt_d       = '0;
          state_d     = ST_TX_BODY;
        end
      end
      ST_TX_BODY: if (sd_tick) begin
        cmd_out_d = tx_sr_q[39];
        cmd_oe_d  = 1'b1;
        crc_en_c  = 1'b1;
        crc_in_c  = tx_sr_q[39];
        tx_sr_d   = {tx_sr_q[38:0], 1'b0};
        if (cnt_q == CNT_W'(39)) begin
          cnt_d   = '0;
          state_d = ST_TX_CRC;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_TX_CRC: if (sd_tick) begin
        cmd_out_d = crc_w[3'd6 - cnt_q[2:0]];
        if (cnt_q == CNT_W'(6)) begin
          cnt_d   = '0;
          state_d = ST_TX_END;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      // First tick drives the end bit, second tick releases the line
      ST_TX_END: if (sd_tick) begin
        cmd_out_d = 1'b1;
        if (cnt_q == '0) begin
          cnt_d = CNT_W'(1);
        end else begin
          cmd_oe_d = 1'b0;
          cnt_d    = '0;
          if (rtype_q == 2'd0) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_DONE;
          end else begin
            crc_clear_c = 1'b1;
            wait_d      = '0;
            state_d     = ST_RESP_WAIT;
          end
        end
      end
      ST_RESP_WAIT: if (sd_tick) begin
        if (!cmd_in) begin
          rx_sr_d[rx_last_c] = 1'b0;
          crc_en_c           = !is_long_c;
          cnt_d              = CNT_W'(1);
          state_d            = ST_RESP_RX;
        end else if (wait_q == WAIT_W'(TIMEOUT_TICKS - 1)) begin
          tout_d  = 1'b1;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_DONE;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      ST_RESP_RX: if (sd_tick) begin
        rx_sr_d[rx_last_c - cnt_q] = cmd_in;
        crc_en_c = crc_win_c;
        crc_in_c = cmd_in;
        if (cnt_q == rx_last_c) begin
          resp_d = RESP_W'(rx_sr_d[39:8]);
`ifdef SD_CMD_LONG_RESP_EN
          if (is_long_c) resp_d = rx_sr_d[127:0];
`endif
          if (rtype_q != 2'd2 && rx_sr_d[7:1] != crc_w) crcerr_d = 1'b1;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      wait_q    <= '0;
      tx_sr_q   <= '0;
      rx_sr_q   <= '0;
      rtype_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      tout_q    <= 1'b0;
      crcerr_q  <= 1'b0;
      resp_q    <= '0;
      cmd_out_q <= 1'b1;
      cmd_oe_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wait_q    <= wait_d;
      tx_sr_q   <= tx_sr_d;
      rx_sr_q   <= rx_sr_d;
      rtype_q   <= rtype_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      tout_q    <= tout_d;
      crcerr_q  <= crcerr_d;
      resp_q    <= resp_d;
      cmd_out_q <= cmd_out_d;
      cmd_oe_q  <= cmd_oe_d;
    end
  end

  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.resp_timeout = tout_q;
  assign bus.resp_crc_err = crcerr_q;
  assign bus.resp         = resp_q;
  assign cmd_out          = cmd_out_q;
  assign cmd_oe           = cmd_oe_q;
endmodule

// File: tb/tb_sd_cmd_engine.sv
// Directed bench for sd_cmd_engine: command frames, response capture/CRC, timeout and mid-frame reset.
// Long-response cases follow SD_CMD_LONG_RESP_EN.
module tb_sd_cmd_engine;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic cmd_in = 1'b1;
  logic cmd_out, cmd_oe;
  logic sd_tick;
  int unsigned div_q = 0;
  int checks = 0;
  int failures = 0;

  sd_cmd_engine_if bus ();

  sd_cmd_engine #(.TIMEOUT_TICKS(64)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .sd_tick (sd_tick),
    .bus     (bus),
    .cmd_out (cmd_out),
    .cmd_oe  (cmd_oe),
    .cmd_in  (cmd_in)
  );

  always #5 clk = ~clk;

  // One tick every 4 clocks
  always @(posedge clk) div_q <= (div_q + 1) % 4;
  assign sd_tick = (div_q == 3);

  initial begin
    #3ms;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [135:0] got, input logic [135:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] crc7(input logic [135:0] v, input int n);
    logic [6:0] c = '0;
    logic fb;
    for (int i = n - 1; i >= 0; i--) begin
      fb = v[i] ^ c[6];
      c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    end
    return c;
  endfunction

  function automatic logic [47:0] make_frame(input logic [5:0] idx, input logic [31:0] arg);
    logic [39:0] body = {2'b01, idx, arg};
    return {body, crc7(136'(body), 40), 1'b1};
  endfunction

  // Waits for the next clock edge on which sd_tick is sampled high
  task automatic next_tick();
    int n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (!sd_tick && n < 16);
    if (!sd_tick) check_val("tick_bound", 0, 1);
  endtask

  task automatic run_cmd(input string tag, input logic [5:0] idx, input logic [31:0] arg,
                         input logic [1:0] rt, input logic [47:0] exp_frame,
                         input logic [135:0] rbits, input int nbits, input int delay,
                         input bit exp_crc, input logic [127:0] exp_resp);
    logic [47:0] fr;
    logic oe_all;
    @(negedge clk);
    bus.start = 1'b1; bus.cmd_index = idx; bus.cmd_arg = arg; bus.resp_type = rt;
    @(negedge clk);
    bus.start = 1'b0;
    check_val({tag, ":busy_rise"}, 136'(bus.busy), 1);
    fr = '0;
    oe_all = 1'b1;
    for (int i = 0; i < 48; i++) begin
      next_tick();
      #1;
      fr[47-i] = cmd_out;
      oe_all   = oe_all & cmd_oe;
      if (i == 10) begin
        // start while busy must be ignored
        bus.start = 1'b1; bus.cmd_index = 6'd5;
        @(posedge clk);
        #1;
        bus.start = 1'b0; bus.cmd_index = idx;
      end
    end
    check_val({tag, ":frame"}, 136'(fr), 136'(exp_frame));
    check_val({tag, ":oe_48"}, 136'(oe_all), 1);
    next_tick();
    #1;
    check_val({tag, ":oe_off"}, 136'(cmd_oe), 0);
    if (rt == 2'd0) begin
      check_val({tag, ":done"}, 136'(bus.done), 1);
      check_val({tag, ":busy_off"}, 136'(bus.busy), 0);
      check_val({tag, ":flags"}, 136'({bus.resp_timeout, bus.resp_crc_err}), 0);
    end else if (nbits == 0) begin
      cmd_in = 1'b1;
      for (int w = 1; w <= 64; w++) begin
        next_tick();
        #1;
        if (w == 63) check_val({tag, ":done_early"}, 136'(bus.done), 0);
      end
      check_val({tag, ":done"}, 136'(bus.done), 1);
      check_val({tag, ":timeout"}, 136'(bus.resp_timeout), 1);
      check_val({tag, ":crc_err"}, 136'(bus.resp_crc_err), 0);
    end else begin
      cmd_in = 1'b1;
      for (int d = 0; d < delay; d++) begin
        next_tick();
        #1;
      end
      cmd_in = rbits[135];
      for (int k = 0; k < nbits; k++) begin
        next_tick();
        #1;
        if (k < nbits - 1) cmd_in = rbits[134-k];
      end
      cmd_in = 1'b1;
      check_val({tag, ":done"}, 136'(bus.done), 1);
      check_val({tag, ":busy_off"}, 136'(bus.busy), 0);
      check_val({tag, ":timeout"}, 136'(bus.resp_timeout), 0);
      check_val({tag, ":crc_err"}, 136'(bus.resp_crc_err), 136'(exp_crc));
      check_val({tag, ":resp"}, 136'(bus.resp), 136'(exp_resp));
    end
    @(posedge clk);
    #1;
    check_val({tag, ":done_pulse"}, 136'(bus.done), 0);
  endtask

  logic [47:0]  r7, r7_bad;
  logic [135:0] cid;
  logic [127:0] cid_resp;
  bit           cid_crc;
  logic [47:0]  fr_part;
  logic         done_seen;

  initial begin
    bus.start = 1'b0; bus.cmd_index = '0; bus.cmd_arg = '0; bus.resp_type = '0;
    r7 = {2'b00, 6'd8, 32'h0000_01AA, 8'h00};
    r7[7:1] = crc7(136'(r7[47:8]), 40);
    r7[0] = 1'b1;
    r7_bad = r7;
    r7_bad[3] = ~r7_bad[3];
    cid = {2'b00, 6'h3F, 120'h035344535531364780123456780123, 8'h00};
    cid[7:1] = crc7(136'(cid[127:8]), 120);
    cid[0] = 1'b1;
`ifdef SD_CMD_LONG_RESP_EN
    cid_resp = cid[127:0];
    cid_crc  = 1'b0;
`else
    cid_resp = 128'(cid[127:96]);
    cid_crc  = (crc7(136'(cid[135:96]), 40) != cid[95:89]);
`endif

    repeat (3) @(posedge clk);
    #1;
    check_val("rst:cmd_out", 136'(cmd_out), 1);
    check_val("rst:cmd_oe", 136'(cmd_oe), 0);
    check_val("rst:busy_done", 136'({bus.busy, bus.done}), 0);
    check_val("rst:flags", 136'({bus.resp_timeout, bus.resp_crc_err}), 0);
    check_val("rst:resp", 136'(bus.resp), 0);
    @(negedge clk);
    reset_n = 1'b1;

    run_cmd("cmd0", 6'd0, 32'h0, 2'd0, 48'h40_0000_0000_95, '0, 0, 0, 1'b0, '0);
    run_cmd("cmd8_r7", 6'd8, 32'h1AA, 2'd1, 48'h48_0000_01AA_87, {r7, 88'h0}, 48, 5,
            1'b0, 128'h1AA);
    run_cmd("cmd8_tout", 6'd8, 32'h1AA, 2'd1, 48'h48_0000_01AA_87, '0, 0, 0, 1'b0, '0);
`ifdef SD_CMD_LONG_RESP_EN
    run_cmd("cmd2_r2", 6'd2, 32'h0, 2'd3, make_frame(6'd2, 32'h0), cid, 136, 3, cid_crc, cid_resp);
`else
    run_cmd("cmd2_r2", 6'd2, 32'h0, 2'd3, make_frame(6'd2, 32'h0), cid, 48, 3, cid_crc, cid_resp);
`endif
    run_cmd("cmd8_badcrc", 6'd8, 32'h1AA, 2'd1, 48'h48_0000_01AA_87, {r7_bad, 88'h0}, 48, 5,
            1'b1, 128'h1AA);
    run_cmd("cmd8_r3_badcrc", 6'd8, 32'h1AA, 2'd2, 48'h48_0000_01AA_87, {r7_bad, 88'h0}, 48, 2,
            1'b0, 128'h1AA);

    // Reset while bit 20 of the body is on the line
    @(negedge clk);
    bus.start = 1'b1; bus.cmd_index = 6'd8; bus.cmd_arg = 32'h1AA; bus.resp_type = 2'd0;
    @(negedge clk);
    bus.start = 1'b0;
    fr_part = '0;
    for (int i = 0; i < 21; i++) begin
      next_tick();
      #1;
      fr_part[47-i] = cmd_out;
    end
    check_val("rstmid:partial", 136'(fr_part[47:27]), 136'(21'h09_0000));
    reset_n = 1'b0;
    #1;
    check_val("rstmid:cmd", 136'({cmd_oe, cmd_out}), 136'(2'b01));
    check_val("rstmid:busy", 136'(bus.busy), 0);
    done_seen = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
      done_seen = done_seen | bus.done;
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (6) begin
      @(posedge clk);
      #1;
      done_seen = done_seen | bus.done;
    end
    check_val("rstmid:no_done", 136'(done_seen), 0);
    run_cmd("post_rst", 6'd8, 32'h1AA, 2'd0, 48'h48_0000_01AA_87, '0, 0, 0, 1'b0, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sd_cmd_engine.md
# sd_cmd_engine

SD host command-line sequencer. Accepts a command (index, argument, response type) from the register interface and serialises the 48-bit command frame onto CMD, computing CRC7 on the fly with an internal `sd_crc7` instance (driving its `clear`/`enable`/`in_bit`). It then optionally receives and CRC-checks the card's response. It sits between the SD host register block and the CMD pad, advancing one bit per SD clock strobe from the clock divider.

## Interface
- `TIMEOUT_TICKS`, default 64: maximum `sd_tick`s (Ncr) to wait for a response start bit; must be ≥2.
- `clk` in 1: system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `sd_tick` in 1: one-`clk` strobe; all CMD bit activity advances only on cycles where it is 1.
- `start` in 1: request; accepted only when `busy`=0.
- `cmd_index` in 6: command index, sampled at acceptance.
- `cmd_arg` in 32: argument, sampled at acceptance.
- `resp_type` in 2: 0 none, 1 48-bit with CRC check, 2 48-bit no CRC check (R3), 3 136-bit (R2).
- `busy` out 1: command in progress.
- `done` out 1: one-`clk` pulse at completion.
- `resp_timeout` out 1: sticky; no start bit within `TIMEOUT_TICKS`.
- `resp_crc_err` out 1: sticky; response CRC mismatch.
- `resp` out 128 (32 without macro): captured response.
- `cmd_out` out 1: CMD drive value.
- `cmd_oe` out 1: CMD output enable.
- `cmd_in` in 1: CMD pad input, already synchronised.

## Operation
- Reset values: `busy`=0, `done`=0, `resp_timeout`=0, `resp_crc_err`=0, `resp`=0, `cmd_out`=1, `cmd_oe`=0. State is IDLE and the CRC register is cleared.
- States: IDLE → TX_BODY → TX_CRC → TX_END → (RESP_WAIT → RESP_RX →) DONE → IDLE.
- IDLE, `start`=1: latch the inputs, clear both sticky flags, clear the CRC, set `busy`, enter TX_BODY.
- TX_BODY: 40 bits, MSB first: `0`, `1`, `cmd_index[5:0]`, `cmd_arg[31:0]`. CRC is enabled on each of those bits.
- TX_CRC: 7 bits, crc[6] first. The CRC is not enabled during this phase.
- TX_END: drive `1`.
- At the tick ending TX_END, `cmd_oe`→0. If `resp_type`=0, go to DONE. Otherwise clear the CRC and go to RESP_WAIT.
- RESP_WAIT: sample `cmd_in` each tick.
  - `0` → RESP_RX, with bit 0 (the start bit) counted.
  - Otherwise increment the wait counter. After `TIMEOUT_TICKS` ticks with no start bit, set `resp_timeout` and go to DONE.
- RESP_RX: shift in N bits total, where N=48 (types 1, 2) or 136 (type 3). Received frame is r[N-1:0], r[N-1] first.
  - CRC over r[47:8] (short) or r[127:8] (long). The 8 header bits of a long response are excluded from the CRC.
  - Compare against r[7:1]. Types 1 and 3 set `resp_crc_err` on mismatch; type 2 never sets it. The end bit is not checked.
  - Capture: short → `resp[31:0]`=r[39:8], upper bits 0. Long → `resp[127:0]`=r[127:0].
  - `resp` updates even on CRC error.
- DONE: pulse `done` for one `clk`, clear `busy`, return to IDLE.
- `start` while `busy`=1 is ignored and not queued.
- `reset_n` low mid-operation: immediately return to the reset values. A partial frame is abandoned, CMD is released and no `done` is issued.

## Timing
- `busy` rises the `clk` after acceptance.
- The first frame bit (`0`) appears on `cmd_out` with `cmd_oe`=1 at the first `sd_tick` after acceptance. Each bit is held until the next tick.
- `cmd_oe` is high for exactly 48 ticks.
- `resp_type`=0: `done` is asserted in the `clk` after the 49th tick.
- Response: `done` is asserted one `clk` after the tick sampling the last response bit, or one `clk` after the timeout tick.
- `cmd_in` is sampled only on ticks where `cmd_oe`=0.
- Sticky flags and `resp` hold until the next acceptance. `done`=1 and `busy`=0 are never both 1 with `busy` still asserted for the same command.

## Configuration
- `SD_CMD_LONG_RESP_EN` defined: 136-bit (R2) support; `resp` is 128 bits.
- `SD_CMD_LONG_RESP_EN` undefined: `resp` is 32 bits, `resp_type`=3 behaves exactly as type 1, and the RX counter is sized for 48 bits.

## Test plan
- CMD0, arg 0x00000000, type 0, `sd_tick` every 4 `clk` → CMD bits 0x40 00 00 00 00 95. `cmd_oe` is high 48 ticks, then `done`, with no flags set.
- CMD8, arg 0x000001AA, type 1 → frame 0x48 00 00 01 AA 87. Bench answers after 5 ticks with a model-generated valid R7 → `resp`=0x000001AA, `resp_crc_err`=0.
- Same as the previous case, but one response CRC bit is flipped → `resp_crc_err`=1 and `resp` still updated. The same flip with type 2 → `resp_crc_err`=0.
- Type 1, `cmd_in` held 1, `TIMEOUT_TICKS`=64 → `resp_timeout`=1 and `done` one `clk` after the 64th wait tick.
- Type 3 (macro on), valid 136-bit CID from the model → `resp` equals r[127:0] and no CRC error. With the macro off, the same stimulus behaves as a 48-bit read.
- `reset_n` pulsed low during TX_BODY bit 20 → `cmd_oe`=0, `cmd_out`=1, `busy`=0 immediately and no `done`. The next `start` sends a correct full frame.
